// File: rtl/int_ctrl.sv
// Interrupt controller: per-source pending latch (level or edge), mask, and a
// registered masked output with a lowest-index-wins ID register.

module int_src (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode,
  input  logic clr,
  output logic pend
);
  logic irq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_d <= irq;
      if (!mode)              pend <= irq;
      else if (irq && !irq_d) pend <= 1'b1;   // set beats a simultaneous clear
      else if (clr)           pend <= 1'b0;
    end
  end
endmodule

module int_ctrl #(
  parameter int NUM_SRC = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ADD_I,
  input  logic        WE,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [5:0]  IRQ_I,
  output logic [7:2]  HWInt
);
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_ID   = 2'd3;

  logic [NUM_SRC-1:0] pend, mask, mode, clr, act;
  logic [2:0]         idx;
  logic               vld;

  assign clr = (WE && ADD_I == A_PEND) ? DAT_I[NUM_SRC-1:0] : '0;
  assign act = pend & mask;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      int_src u_src (
        .clk   (clk),
        .reset (reset),
        .irq   (IRQ_I[k]),
        .mode  (mode[k]),
        .clr   (clr[k]),
        .pend  (pend[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mask  <= '0;
      mode  <= '0;
      HWInt <= '0;
    end else begin
      if (WE && ADD_I == A_MASK) mask <= DAT_I[NUM_SRC-1:0];
      if (WE && ADD_I == A_MODE) mode <= DAT_I[NUM_SRC-1:0];
      HWInt <= act;
    end
  end

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    idx = 3'd7;
    vld = 1'b0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      if (act[k]) begin
        idx = 3'(k);
        vld = 1'b1;
      end
    end
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      A_PEND:  DAT_O[NUM_SRC-1:0] = pend;
      A_MASK:  DAT_O[NUM_SRC-1:0] = mask;
      A_MODE:  DAT_O[NUM_SRC-1:0] = mode;
      A_ID:    DAT_O = {vld, 28'b0, idx};
      default: DAT_O = '0;
    endcase
  end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port ADD_I  input  2  register word select (byte offset [3:2]) driven by bridge.
REQ-004 SHALL have port WE  input  1  register write enable from bridge.
REQ-005 SHALL have port DAT_I  input  32  write data from bridge.
REQ-006 SHALL have port DAT_O  output  32  read data to bridge, combinational on ADD_I.
REQ-007 SHALL have port IRQ_I  input  6  raw interrupt requests from devices (bit0 = timer, bit1 = sw, bit2 = segment, bits 5:3 spare).
REQ-008 SHALL have port HWInt  output  6 ([7:2])  masked pending interrupts to CPU; HWInt[k+2] corresponds to source k.

Function
REQ-009 SHALL hold registers PEND[5:0], MASK[5:0], MODE[5:0] (1 = edge, 0 = level) and IRQ_D[5:0] (IRQ_I delayed one cycle).
REQ-010 SHALL map the registers as: ADD_I=0 PEND (read; write-1-to-clear), 1 MASK (R/W), 2 MODE (R/W), 3 ID (read-only; writes ignored).
REQ-011 SHALL return unused DAT_O bits as 0 for PEND/MASK/MODE reads.
REQ-012 SHALL update MASK or MODE from DAT_I[5:0] on the clk edge where WE=1 and the matching ADD_I is selected; DAT_I[31:6] ignored.
REQ-013 SHALL, for a level-mode source k, load PEND[k] <= IRQ_I[k] every cycle; W1C writes to level-mode bits have no effect.
REQ-014 SHALL, for an edge-mode source k, set PEND[k] on a cycle where IRQ_I[k]=1 and IRQ_D[k]=0, and hold it until cleared.
REQ-015 SHALL clear edge-mode PEND[k] on the edge where WE=1, ADD_I=0, DAT_I[k]=1.
REQ-016 SHALL give set priority over clear when a rising edge and a W1C hit the same edge-mode bit in the same cycle (PEND[k] stays 1).
REQ-017 SHALL latch PEND independently of MASK; masking only gates HWInt and ID.
REQ-018 SHALL register HWInt: HWInt[k+2] <= PEND[k] & MASK[k], i.e. one cycle after PEND changes, two cycles after an IRQ_I edge.
REQ-019 SHALL drive ID read as {VALID, 28'b0, IDX[2:0]}: IDX = lowest k with PEND[k]&MASK[k]=1 (source 0 highest priority), VALID = 1; if none, DAT_O = 32'h0000_0007.
REQ-020 SHALL clear a source-k edge-mode bit without affecting other PEND bits.
REQ-021 SHALL, when MODE[k] changes from level to edge, keep the current PEND[k] value and begin edge detection the next cycle; edge-to-level reloads from IRQ_I next cycle.
REQ-022 SHALL update IRQ_D <= IRQ_I every cycle (not gated by MASK or MODE).

Reset
REQ-023 SHALL on reset=1 at a clk edge set PEND=0, MASK=0, MODE=0, IRQ_D=0, HWInt=0, overriding any simultaneous WE or IRQ_I activity.
REQ-024 SHALL, with reset asserted mid-operation, discard all pending interrupts; the first edge detection after reset release compares against IRQ_D=0, so an IRQ_I held high across reset registers as an edge.
REQ-025 SHALL present DAT_O for ID after reset as 32'h0000_0007.

Verification
REQ-026 Level: MASK=6'h01, MODE=0, IRQ_I[0]=1 at edge n -> PEND[0]=1 after edge n, HWInt[2]=1 after n+1; IRQ_I[0]=0 -> HWInt[2]=0 two edges later.
REQ-027 Edge + W1C: MODE=6'h02, MASK=6'h02, pulse IRQ_I[1] one cycle -> HWInt[3]=1 held; write PEND with DAT_I=32'h2 -> HWInt[3]=0 one edge after PEND clears.
REQ-028 Set-vs-clear race: edge-mode source 1, rising IRQ_I[1] in same cycle as W1C of bit 1 -> PEND[1]=1 afterwards.
REQ-029 Priority: PEND=6'b100110, MASK=6'h3F -> ID read 32'h8000_0001; MASK=6'h3C -> 32'h8000_0002; MASK=0 -> 32'h0000_0007, HWInt=0.
REQ-030 Masked latch: edge source 2, MASK[2]=0, pulse IRQ_I[2] -> PEND read 32'h4, HWInt=0; set MASK=6'h04 -> HWInt[4]=1 one edge later.
REQ-031 Reset mid-operation: PEND=6'h3F, MASK=6'h3F, assert reset with WE=1 to MASK -> MASK=0, PEND=0, HWInt=0, ID=32'h0000_0007.
